rob_superscalar: RTL and testbench

- Parametrised successor to the single-issue reorder buffer: N-way in-order dispatch, M-way out-of-order completion, and K-way in-order retire.
- Circular buffer of ROB_DEPTH entries, with occupancy tracked by an explicit counter rather than a spare slot.
- Branch recovery is precise: a mispredicted branch flushes all younger entries when it reaches retire, not at execute.
- Sits between the dispatch stage (instruction buffer / map table) and the architectural register file / fetch redirect.

---
 rtl/rob_superscalar.sv | 181 ++++++++++++++++++
 tb/tb_rob_superscalar.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_superscalar.sv
// Superscalar reorder buffer: N-way in-order dispatch, M-way out-of-order completion,
// K-way in-order retire, with precise branch recovery at retire time.
module rob_superscalar #(
   parameter int ROB_DEPTH = 16,
   parameter int DP_WIDTH  = 2,
   parameter int CDB_WIDTH = 2,
   parameter int RT_WIDTH  = 2,
   parameter int XLEN      = 32,
   parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DP_WIDTH-1:0]           dp_valid,
   input  logic [DP_WIDTH-1:0]           dp_has_dest,
   input  logic [DP_WIDTH*5-1:0]         dp_dest,
   input  logic [DP_WIDTH-1:0]           dp_is_branch,
   output logic [DP_WIDTH-1:0]           dp_accept,
   output logic [DP_WIDTH*TAG_W-1:0]     dp_tag,
   output logic [$clog2(DP_WIDTH+1)-1:0] dp_free,
   input  logic [CDB_WIDTH-1:0]          cdb_valid,
   input  logic [CDB_WIDTH*TAG_W-1:0]    cdb_tag,
   input  logic [CDB_WIDTH*XLEN-1:0]     cdb_value,
   input  logic [CDB_WIDTH-1:0]          cdb_mispred,
   input  logic [CDB_WIDTH*XLEN-1:0]     cdb_target,
   output logic [RT_WIDTH-1:0]           rt_valid,
   output logic [RT_WIDTH-1:0]           rt_has_dest,
   output logic [RT_WIDTH*5-1:0]         rt_dest,
   output logic [RT_WIDTH*XLEN-1:0]      rt_value,
   output logic [RT_WIDTH*TAG_W-1:0]     rt_tag,
   output logic                          squash,
   output logic [XLEN-1:0]               squash_pc,
   output logic [TAG_W-1:0]              head_tag,
   output logic [TAG_W-1:0]              tail_tag,
   output logic [$clog2(ROB_DEPTH+1)-1:0] count,
   output logic                          empty,
   output logic                          full
);

   localparam int CW = $clog2(ROB_DEPTH+1);
   localparam int FW = $clog2(DP_WIDTH+1);

   logic [ROB_DEPTH-1:0] ent_valid;
   logic [ROB_DEPTH-1:0] ent_complete;
   logic [ROB_DEPTH-1:0] ent_has_dest;
   logic [ROB_DEPTH-1:0] ent_is_branch;
   logic [ROB_DEPTH-1:0] ent_mispred;
   logic [4:0]           ent_dest   [ROB_DEPTH];
   logic [XLEN-1:0]      ent_value  [ROB_DEPTH];
   logic [XLEN-1:0]      ent_target [ROB_DEPTH];

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [CW-1:0]    occ;

   logic [TAG_W-1:0] rt_idx  [RT_WIDTH];
   logic [TAG_W-1:0] dp_idx  [DP_WIDTH];
   logic [TAG_W-1:0] cdb_idx [CDB_WIDTH];
   logic [CW-1:0]    rt_count;
   logic [CW-1:0]    acc_count;
   logic [CW-1:0]    free_ent;
   logic [TAG_W-1:0] squash_head;
   logic             blocked;
   logic             run;

   assign head_tag = head;
   assign tail_tag = tail;
   assign count    = occ;
   assign empty    = (occ == '0);
   assign full     = (occ == CW'(ROB_DEPTH));

   // Retire select: a contiguous run of completed entries from head, cut short after
   // the first mispredicted branch, which also raises the squash for this cycle.
   always_comb begin
      rt_valid    = '0;
      rt_has_dest = '0;
      rt_dest     = '0;
      rt_value    = '0;
      rt_tag      = '0;
      squash      = 1'b0;
      squash_pc   = '0;
      squash_head = '0;
      rt_count    = '0;
      blocked     = 1'b0;
      for (int j = 0; j < RT_WIDTH; j++) begin
         rt_idx[j] = head + TAG_W'(j);
         if (!blocked && ent_valid[rt_idx[j]] && ent_complete[rt_idx[j]]) begin
            rt_valid[j]                   = 1'b1;
            rt_has_dest[j]                = ent_has_dest[rt_idx[j]];
            rt_dest[j*5 +: 5]             = ent_dest[rt_idx[j]];
            rt_value[j*XLEN +: XLEN]      = ent_value[rt_idx[j]];
            rt_tag[j*TAG_W +: TAG_W]      = rt_idx[j];
            rt_count                      = rt_count + CW'(1);
            if (ent_mispred[rt_idx[j]]) begin
               squash      = 1'b1;
               squash_pc   = ent_target[rt_idx[j]];
               squash_head = rt_idx[j] + TAG_W'(1);
               blocked     = 1'b1;
            end
         end else begin
            blocked = 1'b1;
         end
      end
   end

   // Dispatch acceptance uses only the registered occupancy, so entries freed by
   // this cycle's retire become available on the following cycle.
   always_comb begin
      free_ent  = CW'(ROB_DEPTH) - occ;
      dp_free   = (free_ent > CW'(DP_WIDTH)) ? FW'(DP_WIDTH) : FW'(free_ent);
      dp_accept = '0;
      dp_tag    = '0;
      acc_count = '0;
      run       = reset && !squash;
      for (int i = 0; i < DP_WIDTH; i++) begin
         dp_idx[i]                = tail + TAG_W'(i);
         dp_tag[i*TAG_W +: TAG_W] = dp_idx[i];
         run                      = run && dp_valid[i] && (FW'(i) < dp_free);
         dp_accept[i]             = run;
         if (run) acc_count = acc_count + CW'(1);
      end
      for (int k = 0; k < CDB_WIDTH; k++) begin
         cdb_idx[k] = cdb_tag[k*TAG_W +: TAG_W];
      end
   end

   // Entry state: completion writes first, retire clears, dispatch allocates; the
   // loop order makes the highest CDB lane win on duplicate tags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ent_valid     <= '0;
         ent_complete  <= '0;
         ent_has_dest  <= '0;
         ent_is_branch <= '0;
         ent_mispred   <= '0;
         for (int e = 0; e < ROB_DEPTH; e++) begin
            ent_dest[e]   <= '0;
            ent_value[e]  <= '0;
            ent_target[e] <= '0;
         end
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (squash) begin
         ent_valid    <= '0;
         ent_complete <= '0;
         ent_mispred  <= '0;
         head         <= squash_head;
         tail         <= squash_head;
         occ          <= '0;
      end else begin
         for (int k = 0; k < CDB_WIDTH; k++) begin
            if (cdb_valid[k] && ent_valid[cdb_idx[k]]) begin
               ent_complete[cdb_idx[k]] <= 1'b1;
               ent_value[cdb_idx[k]]    <= cdb_value[k*XLEN +: XLEN];
               ent_mispred[cdb_idx[k]]  <= cdb_mispred[k] && ent_is_branch[cdb_idx[k]];
               ent_target[cdb_idx[k]]   <= cdb_target[k*XLEN +: XLEN];
            end
         end
         for (int j = 0; j < RT_WIDTH; j++) begin
            if (rt_valid[j]) begin
               ent_valid[rt_idx[j]]    <= 1'b0;
               ent_complete[rt_idx[j]] <= 1'b0;
            end
         end
         for (int i = 0; i < DP_WIDTH; i++) begin
            if (dp_accept[i]) begin
               ent_valid[dp_idx[i]]     <= 1'b1;
               ent_complete[dp_idx[i]]  <= 1'b0;
               ent_mispred[dp_idx[i]]   <= 1'b0;
               ent_has_dest[dp_idx[i]]  <= dp_has_dest[i];
               ent_dest[dp_idx[i]]      <= dp_dest[i*5 +: 5];
               ent_is_branch[dp_idx[i]] <= dp_is_branch[i];
            end
         end
         head <= head + rt_count[TAG_W-1:0];
         tail <= tail + acc_count[TAG_W-1:0];
         occ  <= occ + acc_count - rt_count;
      end
   end

endmodule

// File: tb/tb_rob_superscalar.sv
// Directed bench for rob_superscalar: a vector table for basic dispatch/complete/retire
// plus hand-written sequences for mispredict, wrap, fill and mid-stream reset.
module tb_rob_superscalar;

   logic        clock;
   logic        reset;
   logic [1:0]  dp_valid;
   logic [1:0]  dp_has_dest;
   logic [9:0]  dp_dest;
   logic [1:0]  dp_is_branch;
   logic [1:0]  dp_accept;
   logic [7:0]  dp_tag;
   logic [1:0]  dp_free;
   logic [1:0]  cdb_valid;
   logic [7:0]  cdb_tag;
   logic [63:0] cdb_value;
   logic [1:0]  cdb_mispred;
   logic [63:0] cdb_target;
   logic [1:0]  rt_valid;
   logic [1:0]  rt_has_dest;
   logic [9:0]  rt_dest;
   logic [63:0] rt_value;
   logic [7:0]  rt_tag;
   logic        squash;
   logic [31:0] squash_pc;
   logic [3:0]  head_tag;
   logic [3:0]  tail_tag;
   logic [4:0]  count;
   logic        empty;
   logic        full;

   int assertCount;
   int failCount;

   rob_superscalar dut (
      .clock(clock), .reset(reset),
      .dp_valid(dp_valid), .dp_has_dest(dp_has_dest), .dp_dest(dp_dest),
      .dp_is_branch(dp_is_branch), .dp_accept(dp_accept), .dp_tag(dp_tag), .dp_free(dp_free),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
      .rt_valid(rt_valid), .rt_has_dest(rt_has_dest), .rt_dest(rt_dest),
      .rt_value(rt_value), .rt_tag(rt_tag),
      .squash(squash), .squash_pc(squash_pc),
      .head_tag(head_tag), .tail_tag(tail_tag), .count(count),
      .empty(empty), .full(full)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  dpv;
      logic [1:0]  cv;
      logic [3:0]  t0;
      logic [3:0]  t1;
      logic [1:0]  accept;
      logic [1:0]  rtv;
      logic [31:0] rtval0;
      logic [31:0] rtval1;
      logic [4:0]  cnt;
      logic [3:0]  head;
   } vec_t;

   vec_t vecs [9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CDB lane 0 carries value A000+tag, lane 1 carries B000+tag.
   task automatic applyStimulus(input logic [1:0] dpv, input logic [1:0] br, input logic [1:0] cv,
                                input logic [3:0] t0, input logic [3:0] t1,
                                input logic [1:0] mp, input logic [31:0] tgt);
      dp_valid     = dpv;
      dp_has_dest  = 2'b11;
      dp_dest      = {5'd2, 5'd1};
      dp_is_branch = br;
      cdb_valid    = cv;
      cdb_tag      = {t1, t0};
      cdb_value    = {32'hB000 + 32'(t1), 32'hA000 + 32'(t0)};
      cdb_mispred  = mp;
      cdb_target   = {tgt, tgt};
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      checkOutput("count_bound", 32'(count > 5'd16), 32'd0);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;

      vecs[0] = '{2'b11, 2'b00, 4'd0, 4'd0, 2'b11, 2'b00, 32'h0,    32'h0,    5'd2, 4'd0};
      vecs[1] = '{2'b01, 2'b00, 4'd0, 4'd0, 2'b01, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[2] = '{2'b10, 2'b00, 4'd0, 4'd0, 2'b00, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[3] = '{2'b00, 2'b01, 4'd2, 4'd0, 2'b00, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[4] = '{2'b00, 2'b01, 4'd9, 4'd0, 2'b00, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[5] = '{2'b00, 2'b10, 4'd0, 4'd1, 2'b00, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[6] = '{2'b00, 2'b01, 4'd0, 4'd0, 2'b00, 2'b00, 32'h0,    32'h0,    5'd3, 4'd0};
      vecs[7] = '{2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b11, 32'hA000, 32'hB001, 5'd1, 4'd2};
      vecs[8] = '{2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 2'b01, 32'hA002, 32'h0,    5'd0, 4'd3};

      // Outputs while held in reset, with dispatch requested.
      reset = 1'b0;
      applyStimulus(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #12;
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_accept", 32'(dp_accept), 32'd0);
      checkOutput("rst_free", 32'(dp_free), 32'd2);
      checkOutput("rst_rtvalid", 32'(rt_valid), 32'd0);
      checkOutput("rst_squash", 32'(squash), 32'd0);
      applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      reset = 1'b1;
      tick();

      // Vector table: dispatch, out-of-order completion, in-order retire.
      for (int v = 0; v < 9; v++) begin
         applyStimulus(vecs[v].dpv, 2'b00, vecs[v].cv, vecs[v].t0, vecs[v].t1, 2'b00, 32'h0);
         #2;
         checkOutput($sformatf("v%0d_accept", v), 32'(dp_accept), 32'(vecs[v].accept));
         checkOutput($sformatf("v%0d_rtvalid", v), 32'(rt_valid), 32'(vecs[v].rtv));
         checkOutput($sformatf("v%0d_squash", v), 32'(squash), 32'd0);
         if (vecs[v].rtv[0]) checkOutput($sformatf("v%0d_rtval0", v), rt_value[31:0], vecs[v].rtval0);
         if (vecs[v].rtv[1]) checkOutput($sformatf("v%0d_rtval1", v), rt_value[63:32], vecs[v].rtval1);
         tick();
         checkOutput($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].cnt));
         checkOutput($sformatf("v%0d_head", v), 32'(head_tag), 32'(vecs[v].head));
      end

      // Mispredict: branch at tag 3, younger tags 4 and 5 already complete.
      applyStimulus(2'b11, 2'b01, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      tick();
      applyStimulus(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 2'b11, 4'd5, 4'd4, 2'b00, 32'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 2'b01, 4'd3, 4'd0, 2'b01, 32'h1000);
      #2;
      checkOutput("mp_no_early_retire", 32'(rt_valid), 32'd0);
      tick();
      applyStimulus(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("mp_squash", 32'(squash), 32'd1);
      checkOutput("mp_squash_pc", squash_pc, 32'h1000);
      checkOutput("mp_rtvalid", 32'(rt_valid), 32'b01);
      checkOutput("mp_rttag", 32'(rt_tag[3:0]), 32'd3);
      checkOutput("mp_accept", 32'(dp_accept), 32'd0);
      tick();
      checkOutput("mp_count", 32'(count), 32'd0);
      checkOutput("mp_head", 32'(head_tag), 32'd4);
      checkOutput("mp_tail", 32'(tail_tag), 32'd4);

      // Single-entry round trips walk the pointers from 4 up to 15.
      for (int r = 0; r < 11; r++) begin
         applyStimulus(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
         #2;
         checkOutput($sformatf("walk%0d_tag", r), 32'(dp_tag[3:0]), 32'(4 + r));
         tick();
         applyStimulus(2'b00, 2'b00, 2'b01, 4'(4 + r), 4'd0, 2'b00, 32'h0);
         tick();
         applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
         #2;
         checkOutput($sformatf("walk%0d_rt", r), 32'(rt_valid), 32'b01);
         checkOutput($sformatf("walk%0d_rttag", r), 32'(rt_tag[3:0]), 32'(4 + r));
         tick();
      end
      checkOutput("walk_head", 32'(head_tag), 32'd15);
      checkOutput("walk_tail", 32'(tail_tag), 32'd15);

      // Wrap: dispatch and retire straddling index 15 -> 0.
      applyStimulus(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("wrap_tag0", 32'(dp_tag[3:0]), 32'd15);
      checkOutput("wrap_tag1", 32'(dp_tag[7:4]), 32'd0);
      tick();
      applyStimulus(2'b00, 2'b00, 2'b11, 4'd15, 4'd0, 2'b00, 32'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("wrap_rtvalid", 32'(rt_valid), 32'b11);
      checkOutput("wrap_rttag", 32'(rt_tag), 32'h0F);
      checkOutput("wrap_rtdest1", 32'(rt_dest[9:5]), 32'd2);
      tick();
      checkOutput("wrap_head", 32'(head_tag), 32'd1);
      checkOutput("wrap_tail", 32'(tail_tag), 32'd1);
      checkOutput("wrap_count", 32'(count), 32'd0);

      // Fill to full, then confirm freed entries reappear one cycle after retire.
      for (int c = 0; c < 8; c++) begin
         applyStimulus(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
         #2;
         checkOutput($sformatf("fill%0d_accept", c), 32'(dp_accept), 32'b11);
         tick();
      end
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_count", 32'(count), 32'd16);
      applyStimulus(2'b11, 2'b00, 2'b01, 4'd1, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("full_free", 32'(dp_free), 32'd0);
      checkOutput("full_accept", 32'(dp_accept), 32'd0);
      tick();
      applyStimulus(2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("full_rt", 32'(rt_valid), 32'b01);
      checkOutput("full_no_bypass", 32'(dp_accept), 32'd0);
      tick();
      checkOutput("freed_count", 32'(count), 32'd15);
      applyStimulus(2'b11, 2'b00, 2'b11, 4'd2, 4'd2, 2'b00, 32'h0);
      #2;
      checkOutput("freed_free", 32'(dp_free), 32'd1);
      checkOutput("freed_accept", 32'(dp_accept), 32'b01);
      checkOutput("freed_tag", 32'(dp_tag[3:0]), 32'd1);
      tick();
      applyStimulus(2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("dup_rt", 32'(rt_valid), 32'b01);
      checkOutput("dup_value", rt_value[31:0], 32'hB002);
      tick();
      checkOutput("dup_count", 32'(count), 32'd15);

      // Asynchronous reset in the middle of a cycle with a populated buffer.
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_count", 32'(count), 32'd0);
      checkOutput("mid_rst_empty", 32'(empty), 32'd1);
      checkOutput("mid_rst_rtvalid", 32'(rt_valid), 32'd0);
      checkOutput("mid_rst_squash", 32'(squash), 32'd0);
      reset = 1'b1;
      tick();
      applyStimulus(2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 2'b00, 32'h0);
      #2;
      checkOutput("post_rst_accept", 32'(dp_accept), 32'b01);
      checkOutput("post_rst_tag", 32'(dp_tag[3:0]), 32'd0);
      tick();
      checkOutput("post_rst_count", 32'(count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
